// File: rtl/aes_bist_ctrl.sv
// aes_bist_ctrl -- built-in self-test controller for the AES datapath.
// Latency: first pattern one cycle after the start pulse; done one cycle after the terminating event.
// Backpressure: none; patterns are issued every RUN cycle and responses are accepted whenever valid.
//
// Purpose:
//    Two LFSRs generate key/data patterns that are issued to the AES core for
//    NUM_PATTERNS consecutive cycles. The core's valid responses are compacted
//    into a MISR. The final signature is compared against GOLDEN, and the
//    result is reported as pass/timeout.
//
// Ports:
//    i_clk        single clock, rising edge
//    i_rst        synchronous active-low reset
//    i_start      one-cycle pulse; starts a run from IDLE or DONE, ignored while busy
//    o_key_in     key byte to AES core (key LFSR contents)
//    o_data_in    data byte to AES core (data LFSR contents)
//    o_in_valid   key/data carry a pattern this cycle (RUN)
//    i_data_out   response byte from AES core
//    i_out_valid  response valid this cycle
//    o_busy       high in RUN or DRAIN
//    o_done       high in DONE
//    o_pass       signature matched GOLDEN and no timeout; valid while o_done
//    o_timeout    run ended by response idle timeout; valid while o_done
//    o_signature  live MISR value, or 0 (see below)
//
// Build option:
//    AES_BIST_SIGNATURE_OUT_EN  defined: o_signature drives the live MISR.
//                               undefined: o_signature is tied to 0. The compare
//                               still happens internally.

module aes_bist_ctrl #(
   parameter int unsigned      WIDTH        = 8,
   parameter logic [WIDTH-1:0] KEY_SEED     = 8'hA5,
   parameter logic [WIDTH-1:0] DATA_SEED    = 8'h0F,
   parameter logic [WIDTH-1:0] LFSR_TAPS    = 8'b0110_0011,
   parameter logic [WIDTH-1:0] MISR_TAPS    = 8'b0110_0011,
   parameter int unsigned      NUM_PATTERNS = 256,
   parameter logic [WIDTH-1:0] GOLDEN       = 8'hC0,
   parameter int unsigned      TIMEOUT      = 1024
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   output logic [WIDTH-1:0] o_key_in,
   output logic [WIDTH-1:0] o_data_in,
   output logic             o_in_valid,
   input  logic [WIDTH-1:0] i_data_out,
   input  logic             i_out_valid,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic             o_timeout,
   output logic [WIDTH-1:0] o_signature
);

   // Pattern counters must be able to hold NUM_PATTERNS itself, because the
   // receive count saturates there. The idle counter must be able to hold TIMEOUT.
   localparam int unsigned CW = $clog2(NUM_PATTERNS + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] NP    = CW'(NUM_PATTERNS);
   localparam logic [CW-1:0] NP_M1 = CW'(NUM_PATTERNS - 1);
   localparam logic [TW-1:0] TO_M1 = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Shift left and feed back the parity of the tapped bits.
   function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] taps);
      return {q[WIDTH-2:0], ^(q & taps)};
   endfunction

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_t           r_state;
   logic [WIDTH-1:0] r_key_lfsr;
   logic [WIDTH-1:0] r_data_lfsr;
   logic [WIDTH-1:0] r_misr;
   logic [CW-1:0]    r_sent;
   logic [CW-1:0]    r_rcv;
   logic [TW-1:0]    r_idle;
   logic             r_pass;
   logic             r_timeout;

   // ------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------
   state_t           w_state_nxt;
   logic             w_load;        // reseed and clear for a new run
   logic             w_finish;      // entering DONE this edge
   logic             w_finish_to;   // ... because of the idle timeout
   logic             w_accept;      // response is compacted this cycle
   logic             w_active;
   logic [WIDTH-1:0] w_misr_nxt;
   logic [WIDTH-1:0] w_misr_final;

   assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);

   // Responses after the receive count has saturated do not touch the MISR.
   // The same applies to responses that arrive outside a run.
   assign w_accept   = i_out_valid && w_active && (r_rcv != NP);
   assign w_misr_nxt = f_shift(r_misr, MISR_TAPS) ^ i_data_out;

   // The final response of a run is folded in before the golden compare.
   assign w_misr_final = w_accept ? w_misr_nxt : r_misr;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_finish    = 1'b0;
      w_finish_to = 1'b0;
      o_in_valid  = 1'b0;
      o_busy      = 1'b0;
      o_done      = 1'b0;

      case (r_state)
         S_IDLE, S_DONE: begin
            o_done = (r_state == S_DONE);
            if (i_start) begin
               w_load      = 1'b1;
               w_state_nxt = S_RUN;
            end
         end

         S_RUN: begin
            o_in_valid = 1'b1;
            o_busy     = 1'b1;
            // r_sent counts patterns already issued.
            // This cycle issues pattern r_sent.
            if (r_sent == NP_M1) begin
               w_state_nxt = S_DRAIN;
            end
         end

         S_DRAIN: begin
            o_busy = 1'b1;
            // Completion has priority over timeout.
            // A response that lands on the last idle cycle still counts.
            if ((r_rcv == NP) || (w_accept && (r_rcv == NP_M1))) begin
               w_finish    = 1'b1;
               w_state_nxt = S_DONE;
            end else if (!i_out_valid && (r_idle == TO_M1)) begin
               w_finish    = 1'b1;
               w_finish_to = 1'b1;
               w_state_nxt = S_DONE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Datapath: LFSRs, MISR, counters, result flags
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_key_lfsr  <= KEY_SEED;
         r_data_lfsr <= DATA_SEED;
         r_misr      <= '0;
         r_sent      <= '0;
         r_rcv       <= '0;
         r_idle      <= '0;
         r_pass      <= 1'b0;
         r_timeout   <= 1'b0;
      end else if (w_load) begin
         r_key_lfsr  <= KEY_SEED;
         r_data_lfsr <= DATA_SEED;
         r_misr      <= '0;
         r_sent      <= '0;
         r_rcv       <= '0;
         r_idle      <= '0;
         r_pass      <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         // Patterns advance only while being issued.
         // They hold through DRAIN and DONE.
         if (r_state == S_RUN) begin
            r_key_lfsr  <= f_shift(r_key_lfsr, LFSR_TAPS);
            r_data_lfsr <= f_shift(r_data_lfsr, LFSR_TAPS);
            r_sent      <= r_sent + 1'b1;
         end

         if (w_accept) begin
            r_misr <= w_misr_nxt;
            r_rcv  <= r_rcv + 1'b1;
         end

         // The idle gap is only policed once all patterns are out.
         // Core latency during RUN is unconstrained.
         if (r_state == S_DRAIN) begin
            if (i_out_valid) begin
               r_idle <= '0;
            end else begin
               r_idle <= r_idle + 1'b1;
            end
         end

         if (w_finish) begin
            r_timeout <= w_finish_to;
            r_pass    <= !w_finish_to && (w_misr_final == GOLDEN);
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign o_key_in  = r_key_lfsr;
   assign o_data_in = r_data_lfsr;
   assign o_pass    = r_pass;
   assign o_timeout = r_timeout;

`ifdef AES_BIST_SIGNATURE_OUT_EN
   assign o_signature = r_misr;
`else
   assign o_signature = '0;
`endif

endmodule

// File: tb/tb_aes_bist_ctrl.sv
// tb_aes_bist_ctrl -- directed bench for aes_bist_ctrl with a run-level reference model.
// Latency: core stand-in answers each pattern two cycles after it is issued.
// Backpressure: none; the core stand-in can drop trailing responses to force a timeout.

module tb_aes_bist_ctrl;

   localparam int         NP   = 4;
   localparam int         TO   = 16;
   localparam logic [7:0] KS   = 8'hA5;
   localparam logic [7:0] DS   = 8'h0F;
   localparam logic [7:0] TAPS = 8'b0110_0011;
   localparam logic [7:0] GOLD = 8'h00;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       ov = 1'b0;
   logic [7:0] dout = 8'h00;
   logic [7:0] key_in, data_in, sig;
   logic       in_valid, busy, done, pass, tmo;

   always #5 clk = ~clk;

   aes_bist_ctrl #(
      .WIDTH        (8),
      .KEY_SEED     (KS),
      .DATA_SEED    (DS),
      .LFSR_TAPS    (TAPS),
      .MISR_TAPS    (TAPS),
      .NUM_PATTERNS (NP),
      .GOLDEN       (GOLD),
      .TIMEOUT      (TO)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .o_key_in    (key_in),
      .o_data_in   (data_in),
      .o_in_valid  (in_valid),
      .i_data_out  (dout),
      .i_out_valid (ov),
      .o_busy      (busy),
      .o_done      (done),
      .o_pass      (pass),
      .o_timeout   (tmo),
      .o_signature (sig)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Run-level model.
   // A run is described by the sample index of its first pattern, the number
   // of compacted responses, and the start of the current quiet stretch.
   bit         m_rst = 1'b1;
   bit         m_act = 1'b0;
   bit         m_fin = 1'b0;
   int         m_r0 = 0;
   int         m_acc = 0;
   int         m_quiet0 = 0;
   logic [7:0] m_misr = 8'h00;
   bit         m_pass = 1'b0;
   bit         m_to = 1'b0;

   // Core stand-in.
   int core_mode = 0;
   int core_limit = 0;
   int core_sent = 0;
   int last_resp_cyc = -1;
   int iv_count = 0;
   int due_q[$];

   function automatic logic [7:0] step(input logic [7:0] q);
      return {q[6:0], ^(q & TAPS)};
   endfunction

   function automatic logic [7:0] lfsr_n(input logic [7:0] seed, input int n);
      logic [7:0] q;
      q = seed;
      for (int i = 0; i < n; i++) q = step(q);
      return q;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic compare();
      int steps;
      bit exp_iv;
      exp_iv = m_act && (cyc < m_r0 + NP);
      if (m_act) steps = (cyc - m_r0 < NP) ? (cyc - m_r0) : NP;
      else       steps = m_fin ? NP : 0;
      chk("in_valid", in_valid, exp_iv);
      chk("key_in",   key_in,   lfsr_n(KS, steps));
      chk("data_in",  data_in,  lfsr_n(DS, steps));
      chk("busy",     busy,     m_act);
      chk("done",     done,     m_fin);
      if (m_fin || m_rst) begin
         chk("pass",    pass, m_pass);
         chk("timeout", tmo,  m_to);
      end
`ifdef AES_BIST_SIGNATURE_OUT_EN
      chk("signature", sig, m_misr);
`else
      chk("signature", sig, 8'h00);
`endif
   endtask

   // Advance the model from sample cyc to cyc+1 using the inputs applied at that edge.
   task automatic advance();
      if (!rst) begin
         m_rst = 1'b1; m_act = 1'b0; m_fin = 1'b0;
         m_misr = 8'h00; m_pass = 1'b0; m_to = 1'b0; m_acc = 0;
      end else if (m_act) begin
         if (ov && m_acc < NP) begin
            m_misr   = step(m_misr) ^ dout;
            m_acc++;
            m_quiet0 = (m_r0 + NP > cyc + 1) ? (m_r0 + NP) : (cyc + 1);
         end
         if (m_acc == NP && cyc + 1 >= m_r0 + NP + 1) begin
            m_act = 1'b0; m_fin = 1'b1; m_to = 1'b0;
            m_pass = (m_misr == GOLD);
         end else if (m_acc < NP && cyc + 1 >= m_quiet0 + TO) begin
            m_act = 1'b0; m_fin = 1'b1; m_to = 1'b1; m_pass = 1'b0;
         end
      end else if (start) begin
         m_act = 1'b1; m_fin = 1'b0; m_rst = 1'b0;
         m_r0 = cyc + 1; m_acc = 0; m_misr = 8'h00;
         m_quiet0 = cyc + 1 + NP;
      end
   endtask

   task automatic core();
      if (in_valid) begin
         if (core_sent < core_limit) due_q.push_back(cyc + 2);
         core_sent++;
         iv_count++;
      end
      ov   = 1'b0;
      dout = 8'h00;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         void'(due_q.pop_front());
         ov   = 1'b1;
         dout = (core_mode != 0) ? 8'h5A : 8'h00;
         last_resp_cyc = cyc;
      end
   endtask

   task automatic tick();
      advance();
      @(posedge clk);
      #1;
      cyc++;
      compare();
      core();
   endtask

   task automatic run_start(input int mode, input int limit);
      core_mode = mode; core_limit = limit; core_sent = 0; iv_count = 0;
      due_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 200) begin
         tick();
         n++;
      end
      chk("done_reached", done, 1'b1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_key"},      key_in,   8'hA5);
      chk({tag, "_data"},     data_in,  8'h0F);
      chk({tag, "_in_valid"}, in_valid, 1'b0);
      chk({tag, "_busy"},     busy,     1'b0);
      chk({tag, "_done"},     done,     1'b0);
      chk({tag, "_pass"},     pass,     1'b0);
      chk({tag, "_timeout"},  tmo,      1'b0);
      chk({tag, "_sig"},      sig,      8'h00);
   endtask

   initial begin
      // Reset state.
      repeat (3) tick();
      chk_reset_outputs("reset");
      rst = 1'b1;
      tick();

      // Run 1: zero loopback, 2-cycle latency -> signature 00 matches GOLDEN.
      run_start(0, NP);
      chk("p0_key", key_in, 8'hA5);  chk("p0_data", data_in, 8'h0F);
      tick();
      chk("p1_key", key_in, 8'h4A);  chk("p1_data", data_in, 8'h1E);
      tick();
      chk("p2_key", key_in, 8'h94);  chk("p2_data", data_in, 8'h3D);
      wait_done();
      chk("run1_valid_cycles", iv_count, NP);
      chk("run1_pass",    pass, 1'b1);
      chk("run1_timeout", tmo,  1'b0);
      chk("run1_sig",     sig,  8'h00);
      repeat (2) tick();

      // Run 2: constant 5A responses -> signature 54 != GOLDEN, restart from DONE.
      run_start(1, NP);
      chk("run2_p0_key", key_in, 8'hA5);
      wait_done();
      chk("run2_pass",    pass, 1'b0);
      chk("run2_timeout", tmo,  1'b0);
`ifdef AES_BIST_SIGNATURE_OUT_EN
      chk("run2_sig", sig, 8'h54);
`endif

      // Run 3: only three responses -> timeout 16 cycles after the last one.
      run_start(0, NP - 1);
      wait_done();
      chk("run3_gap",     cyc - (last_resp_cyc + 1), TO);
      chk("run3_timeout", tmo,  1'b1);
      chk("run3_pass",    pass, 1'b0);

      // Run 4: start while busy is ignored; reset mid-DRAIN aborts the run.
      run_start(0, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ignored_start_key", key_in, 8'h4A);
      for (int i = 0; i < 20 && in_valid; i++) tick();
      repeat (3) tick();
      chk("drain_busy", busy, 1'b1);
      rst = 1'b0;
      tick();
      chk_reset_outputs("abort");
      rst = 1'b1;
      tick();
      run_start(0, NP);
      chk("replay_key",  key_in,  8'hA5);
      chk("replay_data", data_in, 8'h0F);
      wait_done();
      chk("run4_pass", pass, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
